// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared widths, default thresholds and timer sizes for sensor_cond
package sensor_pkg;

  // Sensor code and derived widths
  localparam int SENS_W     = 12;
  localparam int ERR_W      = 13;
  localparam int CADP_W     = 8;
  localparam int CURR_ACC_W = 14;
  localparam int TQ_ACC_W   = 17;

  // Default thresholds
  localparam logic [SENS_W-1:0] LOW_BATT_THRES_DFLT = 12'hA98;
  localparam logic [SENS_W-1:0] TORQUE_MIN_DFLT     = 12'h380;

  // Timer widths: sample tick counter and cadence prescaler
  localparam int SMPL_W_NORM  = 16;
  localparam int SMPL_W_FAST  = 12;
  localparam int PRESC_W_NORM = 10;
  localparam int PRESC_W_FAST = 4;

  // Subtract with clamp at zero, so the target current never underflows
  function automatic logic [SENS_W-1:0] sat_sub(input logic [SENS_W-1:0] a,
                                                input logic [SENS_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/cadence_meas.sv
// rtl/cadence_meas.sv - crank pulse synchronizer, edge detect and cadence period measurement
module cadence_meas
  import sensor_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cadence_raw,
  output logic              cad_rise,
  output logic [CADP_W-1:0] cadence_per,
  output logic              not_pedaling
);

  localparam int PW = FAST_SIM ? PRESC_W_FAST : PRESC_W_NORM;
  localparam logic [CADP_W-1:0] PER_SAT = '1;

  logic              sync1_q, sync2_q, prev_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CADP_W-1:0] per_cnt_q, per_cnt_d;
  logic [CADP_W-1:0] cadence_per_q, cadence_per_d;
  logic              not_ped_q;
  logic              presc_tick;

  assign cad_rise     = sync2_q & ~prev_q;
  assign presc_tick   = &presc_q;
  assign cadence_per  = cadence_per_q;
  assign not_pedaling = not_ped_q;

  // Two-flop synchronizer plus a history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= cadence_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state of the period counters; a crank edge clears them even on a tick
  always_comb begin
    presc_d       = presc_q + PW'(1);
    per_cnt_d     = per_cnt_q;
    cadence_per_d = cadence_per_q;
    if (presc_tick && (per_cnt_q != PER_SAT)) begin
      per_cnt_d = per_cnt_q + 8'd1;
    end
    if (cad_rise) begin
      presc_d       = '0;
      per_cnt_d     = '0;
      cadence_per_d = per_cnt_q;
    end
  end

  // Period registers; per_cnt starts saturated so the first edge reports "no period"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      per_cnt_q     <= PER_SAT;
      cadence_per_q <= PER_SAT;
      not_ped_q     <= 1'b1;
    end else begin
      presc_q       <= presc_d;
      per_cnt_q     <= per_cnt_d;
      cadence_per_q <= cadence_per_d;
      not_ped_q     <= (per_cnt_q == PER_SAT) | (cadence_per_q == PER_SAT);
    end
  end

endmodule

// File: rtl/sensor_cond.sv
// rtl/sensor_cond.sv - current/torque filtering, battery flag and current error for the PID stage
module sensor_cond
  import sensor_pkg::*;
#(
  parameter bit                FAST_SIM       = 1'b0,
  parameter logic [SENS_W-1:0] LOW_BATT_THRES = LOW_BATT_THRES_DFLT,
  parameter logic [SENS_W-1:0] TORQUE_MIN     = TORQUE_MIN_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SENS_W-1:0] batt,
  input  logic [SENS_W-1:0] curr,
  input  logic [SENS_W-1:0] torque,
  input  logic              cadence_raw,
  output logic [SENS_W-1:0] avg_curr,
  output logic [SENS_W-1:0] avg_torque,
  output logic [CADP_W-1:0] cadence_per,
  output logic              not_pedaling,
  output logic              low_batt,
  output logic [ERR_W-1:0]  error
);

  localparam int SW = FAST_SIM ? SMPL_W_FAST : SMPL_W_NORM;

  logic                  cad_rise;
  logic [SW-1:0]         smpl_cnt_q;
  logic                  curr_smpl;
  logic [CURR_ACC_W-1:0] curr_accum_q, curr_accum_d;
  logic [TQ_ACC_W-1:0]   tq_accum_q, tq_accum_d;
  logic                  low_batt_q;
  logic [SENS_W-1:0]     target_curr;
  logic [ERR_W-1:0]      error_q, error_d;

  cadence_meas #(
    .FAST_SIM     (FAST_SIM)
  ) u_cadence_meas (
    .clk          (clk),
    .rst_n        (rst_n),
    .cadence_raw  (cadence_raw),
    .cad_rise     (cad_rise),
    .cadence_per  (cadence_per),
    .not_pedaling (not_pedaling)
  );

  assign curr_smpl  = &smpl_cnt_q;
  assign avg_curr   = curr_accum_q[CURR_ACC_W-1:2];
  assign avg_torque = tq_accum_q[TQ_ACC_W-1:5];
  assign low_batt   = low_batt_q;
  assign error      = error_q;

  // Filter updates and target current; torque is re-seeded whenever the rider is idle
  always_comb begin
    curr_accum_d = curr_accum_q;
    tq_accum_d   = tq_accum_q;
    target_curr  = '0;
    if (curr_smpl) begin
      curr_accum_d = curr_accum_q - (curr_accum_q >> 2) + {2'b00, curr};
    end
    if (not_pedaling) begin
      tq_accum_d = {torque, 5'b0};
    end else if (cad_rise) begin
      tq_accum_d = tq_accum_q - (tq_accum_q >> 5) + {5'b0, torque};
    end
    if (!not_pedaling && !low_batt_q) begin
      target_curr = sat_sub(avg_torque, TORQUE_MIN);
    end
    error_d = {1'b0, target_curr} - {1'b0, avg_curr};
  end

  // Sample tick counter, filter accumulators, battery flag and error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_cnt_q   <= '0;
      curr_accum_q <= '0;
      tq_accum_q   <= '0;
      low_batt_q   <= 1'b0;
      error_q      <= '0;
    end else begin
      smpl_cnt_q   <= smpl_cnt_q + SW'(1);
      curr_accum_q <= curr_accum_d;
      tq_accum_q   <= tq_accum_d;
      low_batt_q   <= (batt < LOW_BATT_THRES);
      error_q      <= error_d;
    end
  end

endmodule
